write_back_stage: RTL and testbench
===================================

Name: write_back_stage

Overview:
Final pipeline stage of the RISC-V CPU. It accepts instructions from the memory-access stage through the valid/allow_in handshake and selects the write-back value (load data, link address or ALU result). It drives the register-file write port and the forwarding bus, and presents the retired-instruction record to the commit/difftest interface. It also keeps retired-instruction and branch-misprediction counters.

Parameters:
CNT_W, 64, width of the performance counters
RESET_PC, 32'h8000_0000, reset value of W_cur_pc and W_pred_pc

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_to_w_valid  in  1  M stage holds a valid instruction
w_allow_in  out  1  W can accept this cycle
commit_ready  in  1  commit consumer accepts the record; back-pressure
w_valid  out  1  W holds a valid instruction
M_opcode  in  7  opcode (`OP_* from define.v)
M_funct  in  10  {funct7,funct3}
M_valE  in  32  ALU result
m_valM  in  32  sized and extended load data, combinational from the M-stage RAM
M_rd  in  5  destination register
M_default_pc  in  32  pc+4
M_cur_pc, M_instr, M_pred_pc, M_predicted_pc  in  32 each  commit info
M_commit  in  1  instruction counts as committed
rf_we  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
fwd_w_valid  out  1  forwarding entry valid (equals rf_we)
fwd_w_rd  out  5  forwarding destination
fwd_w_data  out  32  forwarding value (equals rf_wdata)
commit_valid  out  1  retire record valid
W_cur_pc, W_instr, W_pred_pc  out  32 each  retired pc, instruction, actual next pc
W_commit  out  1  registered M_commit
instret_cnt  out  CNT_W  retired-instruction counter
mispred_cnt  out  CNT_W  mispredicted control-flow counter

Behaviour:
- Handshake:
  - w_ready_go = commit_ready.
  - w_allow_in = ~w_valid | (w_ready_go & commit_ready).
  - commit_valid = w_valid & w_ready_go.
- w_valid:
  - rst -> 0.
  - Otherwise, when w_allow_in, w_valid <= m_to_w_valid.
- Capture: when w_allow_in & m_to_w_valid, register opcode, funct, rd, cur_pc, instr, pred_pc, commit and the selected wdata. The two PCs are also compared at capture: mispredict = (M_pred_pc != M_predicted_pc).
- wdata select, one registered cycle after M:
  - `OP_LOAD -> m_valM.
  - `OP_JAL or `OP_JALR -> M_default_pc.
  - Any other opcode -> M_valE.
  - M_funct has no effect on wdata; sizing and extension are completed in M.
- Register-file write:
  - rf_we = w_valid & w_ready_go & has_rd & (W_rd != 0).
  - has_rd is false for `OP_S and `OP_B, true otherwise.
  - Writes to x0 are suppressed.
  - A stalled instruction (commit_ready=0) does not write and is written exactly once, in the cycle it retires.
- Forwarding outputs mirror the rf write signals. While stalled, fwd_w_valid = 0; the decode stage's interlock covers this case.
- Counters, updated on commit_valid:
  - instret_cnt increments when W_commit = 1.
  - mispred_cnt increments when W_commit = 1 and the captured mispredict bit = 1.
  - Both wrap modulo 2^CNT_W.
  - Both reset to 0 on rst only, not on flush.
- Reset values:
  - 0: w_valid, rf_we, fwd_w_valid, commit_valid, W_commit, W_instr, both counters.
  - RESET_PC: W_cur_pc, W_pred_pc.
  - rf_waddr and rf_wdata read 0 while w_valid = 0.
- Simultaneous retire and capture: the old record commits and the new one is captured in the same edge; counters see the old record.
- Reset mid-stall: the pending record is dropped with no rf write and no counter update. The cycle after rst deasserts, w_allow_in = 1.

Decomposition:
- Opcode constants come from the shared define.v. Add `WB_SEL_ALU/`WB_SEL_MEM/`WB_SEL_PC there.
- No package typedefs are required.
- One sub-module is natural: wb_perf_counters (instret and mispred counters, CNT_W parameter).

Test Plan:
1. Write-back select:
   - ADD with rd=5, valE=0x1234 and commit_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, commit_valid=1, instret_cnt 0->1.
   - LW with rd=7, m_valM=0xDEADBEEF -> rf_wdata=0xDEADBEEF.
   - JAL with rd=1, default_pc=0x80000014 -> rf_wdata=0x80000014.
2. Store and x0:
   - SW -> rf_we=0, commit_valid=1.
   - ADDI with rd=0 -> rf_we=0, instret_cnt still increments.
3. Back-pressure:
   - commit_ready=0 for 3 cycles with w_valid=1 -> w_allow_in=0, rf_we=0, record held.
   - Raise commit_ready -> exactly one write and one instret increment.
4. Mispredict:
   - M_pred_pc=0x80000040, M_predicted_pc=0x80000004, commit=1 -> mispred_cnt +1.
   - Equal PCs -> no increment.
5. Back-to-back: 4 valid instructions on consecutive cycles with commit_ready=1 -> 4 consecutive commit_valid pulses, instret_cnt=4.
6. Reset mid-stall: stalled record plus rst -> w_valid=0, no rf write, counters=0, W_cur_pc=0x80000000.

Source files
------------

// File: rtl/write_back_stage_pkg.sv
// Shared opcode and write-back select constants for the write-back stage,
// with helpers that classify an opcode for write-back purposes.
package write_back_stage_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  function automatic logic [1:0] wb_sel(input logic [6:0] opcode);
    logic [1:0] sel;
    case (opcode)
      OP_LOAD: sel = WB_SEL_MEM;
      OP_JAL:  sel = WB_SEL_PC;
      OP_JALR: sel = WB_SEL_PC;
      default: sel = WB_SEL_ALU;
    endcase
    return sel;
  endfunction

  // Stores and branches carry no destination register.
  function automatic logic has_rd(input logic [6:0] opcode);
    logic r;
    case (opcode)
      OP_S:    r = 1'b0;
      OP_B:    r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/write_back_stage_perf_counters.sv
// Retired-instruction and mispredict counters; wrap modulo 2^CNT_W and clear
// only on reset.
module wb_perf_counters #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_instret,
  input  logic             inc_mispred,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_cnt <= {CNT_W{1'b0}};
      mispred_cnt <= {CNT_W{1'b0}};
    end else begin
      if (inc_instret) begin
        instret_cnt <= instret_cnt + CNT_ONE;
      end
      if (inc_mispred) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: holds one retiring instruction, writes the register
// file, drives forwarding and presents the commit record.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int          CNT_W    = 64,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_to_w_valid,
  output logic             w_allow_in,
  input  logic             commit_ready,
  output logic             w_valid,
  input  logic [6:0]       M_opcode,
  input  logic [9:0]       M_funct,
  input  logic [31:0]      M_valE,
  input  logic [31:0]      m_valM,
  input  logic [4:0]       M_rd,
  input  logic [31:0]      M_default_pc,
  input  logic [31:0]      M_cur_pc,
  input  logic [31:0]      M_instr,
  input  logic [31:0]      M_pred_pc,
  input  logic [31:0]      M_predicted_pc,
  input  logic             M_commit,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_w_valid,
  output logic [4:0]       fwd_w_rd,
  output logic [31:0]      fwd_w_data,
  output logic             commit_valid,
  output logic [31:0]      W_cur_pc,
  output logic [31:0]      W_instr,
  output logic [31:0]      W_pred_pc,
  output logic             W_commit,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic        w_ready_go;
  logic        capture;
  logic [6:0]  w_opcode;
  logic [9:0]  w_funct;
  logic [4:0]  w_rd;
  logic [31:0] w_wdata;
  logic        w_mispred;
  logic [31:0] cap_wdata;
  logic        inc_instret;
  logic        inc_mispred;
  logic        unused_w_funct;

  assign w_ready_go   = commit_ready;
  assign w_allow_in   = ~w_valid | (w_ready_go & commit_ready);
  assign commit_valid = w_valid & w_ready_go;
  assign capture      = w_allow_in & m_to_w_valid;

  // Funct is kept with the record but does not influence write-back.
  assign unused_w_funct = ^w_funct;

  // Write-back value chosen from the M-stage opcode before capture.
  always_comb begin
    cap_wdata = M_valE;
    case (wb_sel(M_opcode))
      WB_SEL_MEM: cap_wdata = m_valM;
      WB_SEL_PC:  cap_wdata = M_default_pc;
      WB_SEL_ALU: cap_wdata = M_valE;
      default:    cap_wdata = M_valE;
    endcase
  end

  // Stage valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid <= 1'b0;
    end else if (w_allow_in) begin
      w_valid <= m_to_w_valid;
    end
  end

  // Instruction record captured on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_opcode  <= 7'd0;
      w_funct   <= 10'd0;
      w_rd      <= 5'd0;
      w_wdata   <= 32'd0;
      w_mispred <= 1'b0;
      W_cur_pc  <= RESET_PC;
      W_instr   <= 32'd0;
      W_pred_pc <= RESET_PC;
      W_commit  <= 1'b0;
    end else if (capture) begin
      w_opcode  <= M_opcode;
      w_funct   <= M_funct;
      w_rd      <= M_rd;
      w_wdata   <= cap_wdata;
      w_mispred <= (M_pred_pc != M_predicted_pc);
      W_cur_pc  <= M_cur_pc;
      W_instr   <= M_instr;
      W_pred_pc <= M_pred_pc;
      W_commit  <= M_commit;
    end
  end

  // A stalled record writes nothing until the cycle it retires.
  assign rf_we    = commit_valid & has_rd(w_opcode) & (w_rd != 5'd0);
  assign rf_waddr = w_valid ? w_rd : 5'd0;
  assign rf_wdata = w_valid ? w_wdata : 32'd0;

  assign fwd_w_valid = rf_we;
  assign fwd_w_rd    = rf_waddr;
  assign fwd_w_data  = rf_wdata;

  assign inc_instret = commit_valid & W_commit;
  assign inc_mispred = inc_instret & w_mispred;

  wb_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .inc_instret(inc_instret),
    .inc_mispred(inc_mispred),
    .instret_cnt(instret_cnt),
    .mispred_cnt(mispred_cnt)
  );

endmodule

// File: tb/tb_write_back_stage.sv
// Randomized and directed bench for write_back_stage against a record-level
// reference model.
module tb_write_back_stage;

  localparam int          CNT_W    = 64;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_S     = 7'b0100011;
  localparam logic [6:0] T_B     = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_SYS   = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, m_to_w_valid, w_allow_in, commit_ready, w_valid;
  logic [6:0]       M_opcode;
  logic [9:0]       M_funct;
  logic [31:0]      M_valE, m_valM, M_default_pc, M_cur_pc, M_instr, M_pred_pc, M_predicted_pc;
  logic [4:0]       M_rd;
  logic             M_commit;
  logic             rf_we, fwd_w_valid, commit_valid, W_commit;
  logic [4:0]       rf_waddr, fwd_w_rd;
  logic [31:0]      rf_wdata, fwd_w_data, W_cur_pc, W_instr, W_pred_pc;
  logic [CNT_W-1:0] instret_cnt, mispred_cnt;

  write_back_stage #(.CNT_W(CNT_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
    .commit_ready(commit_ready), .w_valid(w_valid), .M_opcode(M_opcode), .M_funct(M_funct),
    .M_valE(M_valE), .m_valM(m_valM), .M_rd(M_rd), .M_default_pc(M_default_pc),
    .M_cur_pc(M_cur_pc), .M_instr(M_instr), .M_pred_pc(M_pred_pc),
    .M_predicted_pc(M_predicted_pc), .M_commit(M_commit), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_w_valid(fwd_w_valid),
    .fwd_w_rd(fwd_w_rd), .fwd_w_data(fwd_w_data), .commit_valid(commit_valid),
    .W_cur_pc(W_cur_pc), .W_instr(W_instr), .W_pred_pc(W_pred_pc), .W_commit(W_commit),
    .instret_cnt(instret_cnt), .mispred_cnt(mispred_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: the record currently held in W plus the two counters.
  logic        m_valid, m_commit, m_mis;
  logic [6:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_instr, m_npc, m_wdata;
  logic [63:0] m_icnt, m_mcnt;

  task automatic model_reset();
    m_valid = 1'b0; m_commit = 1'b0; m_mis = 1'b0;
    m_op = 7'd0; m_rd = 5'd0; m_wdata = 32'd0;
    m_pc = RESET_PC; m_npc = RESET_PC; m_instr = 32'd0;
    m_icnt = 64'd0; m_mcnt = 64'd0;
  endtask

  // One clock: drive at the falling edge, check the held record, advance the model.
  task automatic step(input logic r, input logic v, input logic [6:0] op, input logic [4:0] rd,
                      input logic [31:0] vale, input logic [31:0] valm, input logic [31:0] dpc,
                      input logic [31:0] pc, input logic [31:0] ppc, input logic [31:0] pdpc,
                      input logic cm, input logic cr);
    logic        e_allow, e_cv, e_we;
    logic [31:0] instr;
    instr = $urandom;
    @(negedge clk);
    rst = r; m_to_w_valid = v; M_opcode = op; M_funct = 10'($urandom); M_rd = rd;
    M_valE = vale; m_valM = valm; M_default_pc = dpc; M_cur_pc = pc; M_instr = instr;
    M_pred_pc = ppc; M_predicted_pc = pdpc; M_commit = cm; commit_ready = cr;
    #1;
    e_allow = !m_valid || cr;
    e_cv    = m_valid && cr;
    e_we    = e_cv && (m_op != T_S) && (m_op != T_B) && (m_rd != 5'd0);
    check_value("w_valid",      64'(w_valid),      64'(m_valid));
    check_value("w_allow_in",   64'(w_allow_in),   64'(e_allow));
    check_value("commit_valid", 64'(commit_valid), 64'(e_cv));
    check_value("rf_we",        64'(rf_we),        64'(e_we));
    check_value("fwd_w_valid",  64'(fwd_w_valid),  64'(e_we));
    check_value("rf_waddr",     64'(rf_waddr),     64'(m_valid ? m_rd : 5'd0));
    check_value("fwd_w_rd",     64'(fwd_w_rd),     64'(m_valid ? m_rd : 5'd0));
    check_value("rf_wdata",     64'(rf_wdata),     64'(m_valid ? m_wdata : 32'd0));
    check_value("fwd_w_data",   64'(fwd_w_data),   64'(m_valid ? m_wdata : 32'd0));
    check_value("W_cur_pc",     64'(W_cur_pc),     64'(m_pc));
    check_value("W_instr",      64'(W_instr),      64'(m_instr));
    check_value("W_pred_pc",    64'(W_pred_pc),    64'(m_npc));
    check_value("W_commit",     64'(W_commit),     64'(m_commit));
    check_value("instret_cnt",  64'(instret_cnt),  m_icnt);
    check_value("mispred_cnt",  64'(mispred_cnt),  m_mcnt);
    if (r) begin
      model_reset();
    end else begin
      if (e_cv && m_commit) begin
        m_icnt = m_icnt + 64'd1;
        if (m_mis) m_mcnt = m_mcnt + 64'd1;
      end
      if (e_allow) begin
        m_valid = v;
        if (v) begin
          m_op = op; m_rd = rd; m_pc = pc; m_instr = instr; m_npc = ppc;
          m_commit = cm; m_mis = (ppc != pdpc);
          if (op == T_LOAD) m_wdata = valm;
          else if (op == T_JAL || op == T_JALR) m_wdata = dpc;
          else m_wdata = vale;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic cr);
    step(1'b0, 1'b0, T_R, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, cr);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] pc, input logic cr);
    step(1'b0, 1'b1, T_R, rd, $urandom, $urandom, pc + 32'd4, pc, pc + 32'd4, pc + 32'd4, 1'b1, cr);
  endtask

  logic [6:0] ops [10] = '{T_LOAD, T_S, T_B, T_JAL, T_JALR, T_R, T_I, T_LUI, T_AUIPC, T_SYS};

  task automatic random_step();
    logic r, cr, v, cm;
    logic [6:0] op;
    logic [4:0] rd;
    logic [31:0] ppc, pdpc;
    int k;
    r  = ($urandom_range(0, 59) == 0);
    cr = r ? 1'b0 : ($urandom_range(0, 3) != 0);
    v  = ($urandom_range(0, 3) != 0);
    cm = ($urandom_range(0, 7) != 0);
    k  = $urandom_range(0, 10);
    op = (k < 10) ? ops[k] : 7'($urandom);
    rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    ppc  = $urandom;
    pdpc = ($urandom_range(0, 1) == 0) ? ppc : 32'($urandom);
    step(r, v, op, rd, $urandom, $urandom, $urandom, $urandom, ppc, pdpc, cm, cr);
  endtask

  logic [63:0] saved_icnt;

  initial begin
    rst = 1'b1; m_to_w_valid = 1'b0; commit_ready = 1'b0; M_opcode = 7'd0; M_funct = 10'd0;
    M_valE = 32'd0; m_valM = 32'd0; M_rd = 5'd0; M_default_pc = 32'd0; M_cur_pc = 32'd0;
    M_instr = 32'd0; M_pred_pc = 32'd0; M_predicted_pc = 32'd0; M_commit = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();

    // Write-back select: ALU, load and link values.
    step(1'b0, 1'b1, T_R, 5'd5, 32'h0000_1234, 32'h1111_1111, 32'h8000_0004,
         32'h8000_0000, 32'h8000_0004, 32'h8000_0004, 1'b1, 1'b1);
    step(1'b0, 1'b1, T_LOAD, 5'd7, 32'h2222_2222, 32'hDEAD_BEEF, 32'h8000_0008,
         32'h8000_0004, 32'h8000_0008, 32'h8000_0008, 1'b1, 1'b1);
    #1 check_value("instret_after_add", 64'(instret_cnt), 64'd1);
    step(1'b0, 1'b1, T_JAL, 5'd1, 32'h3333_3333, 32'h4444_4444, 32'h8000_0014,
         32'h8000_0010, 32'h8000_0040, 32'h8000_0040, 1'b1, 1'b1);
    // Store and x0 destination.
    step(1'b0, 1'b1, T_S, 5'd3, 32'h5555_5555, 32'h6666_6666, 32'h8000_0044,
         32'h8000_0040, 32'h8000_0044, 32'h8000_0044, 1'b1, 1'b1);
    step(1'b0, 1'b1, T_I, 5'd0, 32'h7777_7777, 32'h8888_8888, 32'h8000_0048,
         32'h8000_0044, 32'h8000_0048, 32'h8000_0048, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    #1 check_value("instret_after_plan12", 64'(instret_cnt), 64'd5);

    // Back-pressure: hold a record for three cycles, then retire it once.
    alu_op(5'd9, 32'h8000_0100, 1'b1);
    repeat (3) alu_op(5'd10, 32'h8000_0200, 1'b0);
    idle(1'b1);
    idle(1'b1);
    #1 check_value("instret_after_stall", 64'(instret_cnt), 64'd6);

    // Mispredict then correctly predicted branch.
    step(1'b0, 1'b1, T_B, 5'd0, 32'd0, 32'd0, 32'h8000_0304, 32'h8000_0300,
         32'h8000_0040, 32'h8000_0004, 1'b1, 1'b1);
    step(1'b0, 1'b1, T_B, 5'd0, 32'd0, 32'd0, 32'h8000_0044, 32'h8000_0040,
         32'h8000_0080, 32'h8000_0080, 1'b1, 1'b1);
    idle(1'b1);
    #1 check_value("mispred_after_branches", 64'(mispred_cnt), 64'd1);

    // Back-to-back retirement.
    saved_icnt = m_icnt;
    for (int i = 0; i < 4; i++) alu_op(5'(i + 11), 32'h8000_0400 + 32'(4 * i), 1'b1);
    idle(1'b1);
    #1 check_value("instret_back_to_back", 64'(instret_cnt), saved_icnt + 64'd4);

    // Reset while a record is stalled.
    alu_op(5'd4, 32'h8000_0500, 1'b1);
    idle(1'b0);
    step(1'b1, 1'b0, T_R, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    check_value("rst_w_valid", 64'(w_valid), 64'd0);
    check_value("rst_instret", 64'(instret_cnt), 64'd0);
    check_value("rst_cur_pc", 64'(W_cur_pc), 64'h8000_0000);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) random_step();
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
